// File: rtl/po2_dot_pkg.sv
// Shared state encoding, weight entry layout and saturation limits for the
// power-of-two dot-product scheduler.
package po2_dot_pkg;

  localparam int W_DEF  = 16;
  localparam int LW_DEF = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

  typedef struct packed {
    logic              neg;
    logic [LW_DEF-1:0] log2;
  } wt_t;

  localparam logic signed [W_DEF-1:0] SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic signed [W_DEF-1:0] SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};

endpackage

// File: rtl/po2_term.sv
// One registered po2 term: optional saturating negation, then arithmetic
// right shift by log2. Result and valid appear one cycle after in_v.
module po2_term
  import po2_dot_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int LW = LW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_v,
  input  logic signed [W-1:0] in_data,
  input  logic                neg,
  input  logic [LW-1:0]       log2,
  output logic                out_v,
  output logic signed [W-1:0] out_term
);

  logic signed [W-1:0] neg_val;
  logic signed [W-1:0] term_d;
  logic signed [W-1:0] term_q;
  logic                v_q;

  always_comb begin
    neg_val = in_data;
    // -(most negative) has no representation; clamp to the positive limit.
    if (neg) neg_val = (in_data == SAT_MIN) ? SAT_MAX : -in_data;
    if (32'(log2) >= W) term_d = {W{neg_val[W-1]}};
    else                term_d = neg_val >>> log2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      term_q <= '0;
    end else begin
      v_q <= in_v;
      if (in_v) term_q <= term_d;
    end
  end

  assign out_v    = v_q;
  assign out_term = term_q;

endmodule

// File: rtl/po2_dot_scheduler.sv
// Streams K elements through a po2 term stage, accumulates and presents the
// saturated dot product on a registered valid/ready output.
module po2_dot_scheduler
  import po2_dot_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int I  = 4,
  parameter int K  = 8,
  parameter int LW = LW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [$clog2(K)-1:0] cfg_addr,
  input  logic                 cfg_neg,
  input  logic [LW-1:0]        cfg_log2,
  output logic                 cfg_ready,
  input  logic                 in_valid,
  input  logic signed [W-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic signed [W-1:0]  out_data,
  input  logic                 out_ready
);

  localparam int CW = $clog2(K);
  localparam int AW = W + CW;

  if (K < 2 || W != W_DEF || LW != LW_DEF || I >= W) begin : g_param_check
    $error("po2_dot_scheduler: unsupported parameter set");
  end

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 ovld_q, ovld_d;
  logic signed [W-1:0]  odat_q, odat_d;
  logic signed [W-1:0]  sat_val;
  wt_t                  tbl_q [K];
  wt_t                  cfg_wt, cur_wt;
  logic                 tbl_we, accept, term_v;
  logic signed [W-1:0]  term;

  assign cfg_ready = rst_n && (state_q == IDLE);
  assign in_ready  = rst_n && (state_q == IDLE || state_q == ACCUM);
  assign out_valid = ovld_q;
  assign out_data  = odat_q;

  assign accept = in_valid && in_ready;
  assign tbl_we = cfg_we && (state_q == IDLE);
  assign cfg_wt = '{neg: cfg_neg, log2: cfg_log2};
  // A write landing with the element-0 accept must be seen by that element.
  assign cur_wt = (tbl_we && cfg_addr == cnt_q) ? cfg_wt : tbl_q[cnt_q];

  po2_term #(.W(W), .LW(LW)) u_term (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_v     (accept),
    .in_data  (in_data),
    .neg      (cur_wt.neg),
    .log2     (cur_wt.log2),
    .out_v    (term_v),
    .out_term (term)
  );

  always_comb begin
    sat_val = acc_q[W-1:0];
    if (acc_q > AW'(SAT_MAX))      sat_val = SAT_MAX;
    else if (acc_q < AW'(SAT_MIN)) sat_val = SAT_MIN;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovld_d  = ovld_q;
    odat_d  = odat_q;
    if (term_v) acc_d = acc_q + AW'(term);
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(K-1)) ? DRAIN : ACCUM;
        end
      end
      DRAIN: state_d = OUTPUT;
      OUTPUT: begin
        // First OUTPUT cycle registers the saturated sum; then hold until taken.
        if (!ovld_q) begin
          ovld_d = 1'b1;
          odat_d = sat_val;
        end else if (out_ready) begin
          ovld_d  = 1'b0;
          odat_d  = '0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovld_q  <= 1'b0;
      odat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovld_q  <= ovld_d;
      odat_q  <= odat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) tbl_q[i] <= '0;
    end else if (tbl_we) begin
      tbl_q[cfg_addr] <= cfg_wt;
    end
  end

endmodule

// File: tb/tb_po2_dot_scheduler.sv
// Scoreboard bench for po2_dot_scheduler: a behavioural model predicts each
// dot product when a vector is driven; results are checked as they leave.
module tb_po2_dot_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic        cfg_neg = 1'b0;
  logic [3:0]  cfg_log2 = '0;
  logic        cfg_ready;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  logic [15:0] vec [8];
  bit          tneg [8];
  int          tlog [8];

  always #5 clk = ~clk;

  po2_dot_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_neg   (cfg_neg),
    .cfg_log2  (cfg_log2),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model();
    longint acc = 0;
    longint v;
    for (int i = 0; i < 8; i++) begin
      v = longint'($signed(vec[i]));
      if (tneg[i]) begin
        v = -v;
        if (v > 32767) v = 32767;
      end
      if (tlog[i] >= 16) v = (v < 0) ? -1 : 0;
      else               v = v >>> tlog[i];
      acc += v;
    end
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  task automatic reset_table_model();
    for (int i = 0; i < 8; i++) begin
      tneg[i] = 1'b0;
      tlog[i] = 0;
    end
  endtask

  task automatic cfg_write(input int a, input bit n, input int l);
    @(negedge clk);
    check("cfg_ready_idle", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_neg = n; cfg_log2 = 4'(l);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tneg[a] = n;
    tlog[a] = l;
  endtask

  task automatic push_elem(input logic [15:0] d, input int gap);
    int n = 0;
    if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // cfg_at: element index during whose handshake cfg_we is held (-1: none).
  task automatic send_vec(input int n, input int gap, input int cfg_at,
                          input int ca, input bit cn, input int cl, input bit push);
    if (cfg_at == 0) begin
      tneg[ca] = cn;
      tlog[ca] = cl;
    end
    if (push) exp_q.push_back(model());
    for (int i = 0; i < n; i++) begin
      if (i == cfg_at) begin
        cfg_we = 1'b1; cfg_addr = 3'(ca); cfg_neg = cn; cfg_log2 = 4'(cl);
      end
      push_elem(vec[i], (i == cfg_at) ? 0 : gap);
      cfg_we = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(exp_q.size() == 0 && !out_valid && in_ready) && n < 100);
    if (n >= 100) check("wait_idle_timeout", 32'(exp_q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
      else                   check("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    reset_table_model();
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_cfg_ready", cfg_ready, 1);

    // Default weights: 8 x 1.0 saturates; exact output latency.
    for (int i = 0; i < 8; i++) vec[i] = 16'h1000;
    send_vec(8, 0, -1, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk); check("lat_pre", out_valid, 0);
    @(negedge clk); check("lat_at", out_valid, 1);
    wait_idle();

    // Negative weight with shift.
    cfg_write(0, 1, 1);
    for (int i = 0; i < 8; i++) vec[i] = 16'h0000;
    vec[0] = 16'h2000;
    send_vec(8, 0, -1, 0, 0, 0, 1);
    wait_idle();

    // Negation of the most negative value and a large shift.
    cfg_write(1, 1, 0);
    cfg_write(2, 0, 15);
    for (int i = 0; i < 8; i++) vec[i] = 16'h0000;
    vec[1] = 16'h8000;
    vec[2] = 16'h8000;
    send_vec(8, 0, -1, 0, 0, 0, 1);
    wait_idle();

    // Input gaps plus output backpressure.
    out_ready = 1'b0;
    vec = '{16'h0400, 16'hF800, 16'h1234, 16'h0010, 16'hC000, 16'h7FFF, 16'h0001, 16'hFFFF};
    send_vec(8, 3, -1, 0, 0, 0, 1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_out_valid", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_data", out_data, exp_q.size() > 0 ? exp_q[0] : 16'hxxxx);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_in_ready", in_ready, 1);
    @(posedge clk); #1;
    vec = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
    send_vec(8, 2, -1, 0, 0, 0, 1);
    wait_idle();

    // cfg writes ignored mid-vector, honoured in IDLE, and bypassed to element 0.
    for (int i = 0; i < 8; i++) vec[i] = 16'h0100;
    vec[3] = 16'h1000;
    send_vec(8, 0, 2, 3, 1, 2, 1);
    wait_idle();
    send_vec(8, 0, -1, 0, 0, 0, 1);
    wait_idle();
    cfg_write(3, 1, 2);
    send_vec(8, 0, -1, 0, 0, 0, 1);
    wait_idle();
    send_vec(8, 0, 0, 0, 0, 3, 1);
    wait_idle();

    // Asynchronous reset mid-vector.
    for (int i = 0; i < 8; i++) vec[i] = 16'h0300;
    send_vec(4, 0, -1, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_cfg_ready", cfg_ready, 0);
    reset_table_model();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) vec[i] = 16'h0800;
    send_vec(8, 0, -1, 0, 0, 0, 1);
    wait_idle();

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/po2_dot_scheduler.md
Name: po2_dot_scheduler

Overview:
- Sequences power-of-two weighted multiplies across one K-element input vector and accumulates them into a single saturated dot-product result.
- Holds a K-entry weight table (sign plus log2 magnitude), written through a config port while idle.
- Streams input elements through one po2 term stage, one element per cycle, then presents the sum on a valid/ready output.
- Sits between an activation stream and the next layer.

Parameters:
- W, 16, element width, signed fixed point.
- I, 4, integer bits in W (Q4.12 default).
- K, 8, elements per dot product. Must be 2 or more.
- LW, 4, width of the log2 weight field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  weight table write strobe.
- cfg_addr  in  $clog2(K)  weight index.
- cfg_neg  in  1  weight sign; 1 means negative.
- cfg_log2  in  LW  right-shift amount (magnitude is 2^-log2).
- cfg_ready  out  1  high only in IDLE.
- in_valid  in  1  input element valid.
- in_data  in  W  signed input element.
- in_ready  out  1  scheduler can accept an element.
- out_valid  out  1  dot-product result valid.
- out_data  out  W  signed saturated result.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, element count=0, accumulator=0, term register invalid.
  - out_valid=0, out_data=0, in_ready=0, cfg_ready=0 while rst_n is low.
  - Every weight entry resets to neg=0, log2=0 (weight +1.0).
  - Reset mid-vector discards all partial work; no output is produced.
- FSM states: IDLE, ACCUM, DRAIN, OUTPUT.
- IDLE:
  - cfg_ready=1 and in_ready=1.
  - cfg_we writes table[cfg_addr].
  - An in_valid&&in_ready handshake accepts element 0, with count=1, and moves to ACCUM.
  - cfg_we and an input handshake in the same cycle: the write takes effect and element 0 uses the newly written weight if cfg_addr==0.
- ACCUM:
  - in_ready=1 and cfg_ready=0.
  - cfg_we is ignored; the table is unchanged.
  - Each handshake accepts element count, looks up table[count] and increments count.
  - The handshake accepting element K-1 moves to DRAIN.
  - in_valid gaps stall the sequence with no penalty.
- Term stage (registered, one cycle):
  - Negative weight: the full two's-complement negation of in_data, not integer-part-only. -(-2^(W-1)) saturates to 2^(W-1)-1.
  - The value is then arithmetically right-shifted by log2.
  - log2 >= W yields 0 for non-negative values and -1 for negative values.
  - Terms are accumulated one cycle after registration into a W+$clog2(K)-bit signed accumulator, with no intermediate overflow.
- DRAIN:
  - Lasts one cycle, while the last term is added.
  - in_ready=0.
  - Moves to OUTPUT.
- OUTPUT:
  - out_valid=1; out_data is the accumulator saturated to W bits (max 0x7FFF, min 0x8000 at W=16).
  - out_data is stable while out_valid && !out_ready.
  - On an out_valid&&out_ready handshake: accumulator=0, count=0, state goes to IDLE.
  - in_ready stays 0 in OUTPUT, so no overlap between vectors.
- Latency:
  - out_valid rises on the 2nd rising edge after the edge accepting element K-1.
  - The next vector can be accepted in the cycle after the output handshake.
  - The minimum period is K+3 cycles.

Decomposition:
- Package po2_dot_pkg holds:
  - the state enum;
  - a weight entry struct {neg, log2[LW-1:0]};
  - saturation limit constants derived from W.
- One sub-module, po2_term:
  - one-cycle registered negate-with-saturation plus arithmetic shift;
  - ports clk, rst_n, in_v, in_data, neg, log2, out_v, out_term.
- The scheduler holds the table, the FSM, the accumulator and the saturation logic.

Test Plan:
- Reset defaults, K=8: inputs 0x1000 x8 with all weights at reset value (+1.0) -> sum 8.0 saturates, out_data=0x7FFF. out_valid rises exactly 2 edges after the 8th accept.
- Negative weight: table[0]={neg=1, log2=1}; in_data[0]=0x2000, others 0 -> out_data=0xF000 (-1.0).
- Negation edge and large shift: table[1]={neg=1, log2=0} with in 0x8000 -> term 0x7FFF. table[2]={neg=0, log2=15} with in 0x8000 -> term 0xFFFF. Other elements 0 -> out_data=0x7FFE.
- Backpressure and gaps: random in_valid gaps; hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0 throughout. After the handshake, in_ready=1 on the next cycle and a second vector computes correctly.
- Config gating: cfg_we during ACCUM to addr 3 -> table unchanged, and the next vector uses the old weight. Write in IDLE -> used by the next vector.
- Async reset after the 4th accept -> out_valid=0 and in_ready=0 immediately, weights back to +1.0. A fresh vector of 0x0800 x8 -> out_data=0x4000.
